// File: rtl/ebus_arb_pkg.sv
// Shared state type, requester indices and default sizing for the EBUS arbiter.
package ebus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    DEMAND  = 2'd2,
    RELEASE = 2'd3
  } tEbusArbState;

  localparam int EBUS_REQ_EDP = 0;
  localparam int EBUS_REQ_IR  = 1;
  localparam int EBUS_REQ_SCD = 2;
  localparam int EBUS_REQ_DTE = 3;

  localparam int EBUS_NREQ    = 4;
  localparam int EBUS_TIMEOUT = 15;

endpackage

// File: rtl/ebus_rr_pick.sv
// Combinational round-robin picker: first requester found searching upward
// from (last+1) mod NREQ with wrap-around.
module ebus_rr_pick
  import ebus_arb_pkg::*;
#(
  parameter int NREQ = EBUS_NREQ,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_last,
  output logic            o_valid,
  output logic [IDXW-1:0] o_winner,
  output logic [NREQ-1:0] o_oneHot
);

  logic [IDXW-1:0] w_cand;

  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    o_oneHot = '0;
    w_cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = IDXW'((int'(i_last) + i) % NREQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid  = 1'b1;
        o_winner = w_cand;
      end
    end
    if (o_valid) o_oneHot[o_winner] = 1'b1;
  end

endmodule

// File: rtl/ebus_arbiter.sv
// EBUS ownership arbiter: round-robin grant, demand/transfer handshake, dead-bus cycle.
// Define EBUS_ARB_TIMEOUT_EN to enable the DEMAND timeout counter and sticky error.
module ebus_arbiter
  import ebus_arb_pkg::*;
#(
  parameter int NREQ    = EBUS_NREQ,
  parameter int TIMEOUT = EBUS_TIMEOUT
) (
  input  logic                    eboxClk,
  input  logic                    eboxResetN,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic                    ebusDemand,
  input  logic                    ebusXfer,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    timeoutErr,
  output logic [$clog2(NREQ)-1:0] errIdx,
  input  logic                    errClr
);

  localparam int         IDXW     = $clog2(NREQ);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  tEbusArbState    r_state;
  tEbusArbState    w_nextState;
  logic [IDXW-1:0] r_last;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            w_pickValid;
  logic [IDXW-1:0] w_pickIdx;
  logic [NREQ-1:0] w_pickOneHot;
  logic            w_ownerReq;
  logic            w_timeoutHit;

  // r_last doubles as the current owner while a bus cycle is in progress.
  assign w_ownerReq = req[r_last];

  ebus_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_valid  (w_pickValid),
    .o_winner (w_pickIdx),
    .o_oneHot (w_pickOneHot)
  );

  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) r_state <= IDLE;
    else             r_state <= w_nextState;
  end

  // A completed transfer outranks both an owner abort and a timeout.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_pickValid) w_nextState = GRANT;
      GRANT:   w_nextState = w_ownerReq ? DEMAND : RELEASE;
      DEMAND: begin
        if (ebusXfer || !w_ownerReq || w_timeoutHit) w_nextState = RELEASE;
      end
      RELEASE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    grant      = '0;
    ebusDemand = 1'b0;
    busy       = (r_state != IDLE);
    done       = r_done;
    if (r_state == GRANT || r_state == DEMAND) grant = r_grant;
    if (r_state == DEMAND) ebusDemand = 1'b1;
  end

  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      r_last  <= IDXW'(NREQ - 1);
      r_grant <= '0;
      r_done  <= '0;
    end else begin
      r_done <= '0;
      if (r_state == IDLE && w_pickValid) begin
        r_last  <= w_pickIdx;
        r_grant <= w_pickOneHot;
      end
      if (r_state == DEMAND && ebusXfer) r_done <= r_grant;
    end
  end

`ifdef EBUS_ARB_TIMEOUT_EN
  logic [7:0]      r_cnt;
  logic            r_timeoutErr;
  logic [IDXW-1:0] r_errIdx;

  assign w_timeoutHit = (r_state == DEMAND) && !ebusXfer && w_ownerReq && (r_cnt >= CNT_LAST);
  assign timeoutErr   = r_timeoutErr;
  assign errIdx       = r_errIdx;

  // Setting a new timeout takes priority over a coincident errClr.
  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      r_cnt        <= 8'd0;
      r_timeoutErr <= 1'b0;
      r_errIdx     <= '0;
    end else begin
      if (r_state == GRANT) r_cnt <= 8'd0;
      else if (r_state == DEMAND && !ebusXfer && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      if (w_timeoutHit) begin
        r_timeoutErr <= 1'b1;
        r_errIdx     <= r_last;
      end else if (errClr) begin
        r_timeoutErr <= 1'b0;
      end
    end
  end
`else
  logic w_unusedCfg;

  assign w_unusedCfg  = errClr | (CNT_LAST == 8'd0);
  assign w_timeoutHit = 1'b0;
  assign timeoutErr   = 1'b0;
  assign errIdx       = '0;
`endif

endmodule

// File: tb/tb_ebus_arbiter.sv
// Self-checking bench for ebus_arbiter: behavioural ownership model plus directed literal checks.
module tb_ebus_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;
`ifdef EBUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       eboxClk = 1'b0;
  logic       eboxResetN;
  logic [3:0] req;
  logic [3:0] grant;
  logic       ebusDemand;
  logic       ebusXfer;
  logic [3:0] done;
  logic       busy;
  logic       timeoutErr;
  logic [1:0] errIdx;
  logic       errClr;

  int total = 0;
  int bad   = 0;

  ebus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .eboxClk    (eboxClk),
    .eboxResetN (eboxResetN),
    .req        (req),
    .grant      (grant),
    .ebusDemand (ebusDemand),
    .ebusXfer   (ebusXfer),
    .done       (done),
    .busy       (busy),
    .timeoutErr (timeoutErr),
    .errIdx     (errIdx),
    .errClr     (errClr)
  );

  always #5 eboxClk = ~eboxClk;

  // Model: owner (-1 = none), age 1 = settle cycle, age >= 2 = data phase,
  // dead = one idle bus cycle after an owner lets go.
  int         mOwner   = -1;
  int         mLast    = NREQ - 1;
  int         mAge     = 0;
  int         mWait    = 0;
  int         mErrIdx  = 0;
  int         mC       = 0;
  bit         mDead    = 1'b0;
  bit         mErr     = 1'b0;
  bit         mSetErr  = 1'b0;
  logic [3:0] mDone    = '0;

  always @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      mOwner = -1; mLast = NREQ - 1; mAge = 0; mWait = 0;
      mDead = 1'b0; mErr = 1'b0; mErrIdx = 0; mDone = '0;
    end else begin
      mSetErr = 1'b0;
      mDone   = '0;
      if (mDead) begin
        mDead = 1'b0;
      end else if (mOwner < 0) begin
        for (int i = 1; i <= NREQ; i++) begin
          mC = (mLast + i) % NREQ;
          if (mOwner < 0 && req[mC[1:0]]) begin
            mOwner = mC;
            mAge   = 1;
          end
        end
        if (mOwner >= 0) mLast = mOwner;
      end else if (mAge == 1) begin
        if (!req[mOwner[1:0]]) begin
          mOwner = -1; mDead = 1'b1;
        end else begin
          mAge = 2; mWait = 0;
        end
      end else begin
        if (ebusXfer) begin
          mDone[mOwner[1:0]] = 1'b1;
          mOwner = -1; mDead = 1'b1;
        end else if (!req[mOwner[1:0]]) begin
          mOwner = -1; mDead = 1'b1;
        end else begin
          mWait++;
          if (TO_EN && mWait >= TIMEOUT) begin
            mSetErr = 1'b1; mErrIdx = mOwner;
            mOwner = -1; mDead = 1'b1;
          end
        end
      end
      if (mSetErr) mErr = 1'b1;
      else if (errClr && TO_EN) mErr = 1'b0;
    end
  end

  function automatic logic [3:0] modelGrant();
    logic [3:0] g;
    g = '0;
    if (mOwner >= 0) g[mOwner[1:0]] = 1'b1;
    return g;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Advance one edge, present the inputs for the coming cycle, then settle to the sample point.
  task automatic applyStimulus(input logic [3:0] r, input logic x, input logic c);
    @(posedge eboxClk);
    #1;
    req      = r;
    ebusXfer = x;
    errClr   = c;
    @(negedge eboxClk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, 1'b0);
  endtask

  always @(negedge eboxClk) begin
    checkOutput("grant", grant, modelGrant());
    checkOutput("ebusDemand", ebusDemand, (mOwner >= 0 && mAge >= 2));
    checkOutput("busy", busy, (mOwner >= 0 || mDead));
    checkOutput("done", done, mDone);
    checkOutput("timeoutErr", timeoutErr, mErr);
    checkOutput("errIdx", errIdx, 2'(mErrIdx));
    checkOutput("grantOneHot", ($countones(grant) <= 1), 1'b1);
  end

  logic [3:0] rrGrant [0:17];
  logic [3:0] rnd;
  int         xferPct;

  initial begin
    eboxResetN = 1'b0;
    req        = '0;
    ebusXfer   = 1'b0;
    errClr     = 1'b0;
    @(negedge eboxClk);
    checkOutput("rstGrant", grant, 4'b0000);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDemand", ebusDemand, 1'b0);
    checkOutput("rstErr", timeoutErr, 1'b0);
    #2 eboxResetN = 1'b1;

    // Round robin from reset (last = 3): 0,1,2,3,0 every four cycles.
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      rrGrant[c] = grant;
    end
    checkOutput("rr1", rrGrant[1], 4'b0001);
    checkOutput("rr2", rrGrant[2], 4'b0001);
    checkOutput("rr3", rrGrant[3], 4'b0000);
    checkOutput("rr4", rrGrant[4], 4'b0000);
    checkOutput("rr5", rrGrant[5], 4'b0010);
    checkOutput("rr9", rrGrant[9], 4'b0100);
    checkOutput("rr13", rrGrant[13], 4'b1000);
    checkOutput("rr17", rrGrant[17], 4'b0001);
    checkOutput("rrModel17", modelGrant(), 4'b0001);
    idleCycles(4);

    // Single requester with immediate transfer.
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("s0Grant", grant, 4'b0000);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("s1Grant", grant, 4'b0001);
    checkOutput("s1Demand", ebusDemand, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("s2Demand", ebusDemand, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("s3Done", done, 4'b0001);
    checkOutput("s3Grant", grant, 4'b0000);
    checkOutput("s3ModelDone", mDone, 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("s4Busy", busy, 1'b0);
    checkOutput("s4Done", done, 4'b0000);
    idleCycles(2);

    // SCD never acknowledged: abandoned after TIMEOUT data cycles when enabled.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    for (int c = 1; c <= 16; c++) applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("to16Demand", ebusDemand, 1'b1);
    checkOutput("to16Err", timeoutErr, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("to17Err", timeoutErr, TO_EN);
    checkOutput("to17ErrIdx", errIdx, TO_EN ? 2'd2 : 2'd0);
    checkOutput("to17Demand", ebusDemand, !TO_EN);
    checkOutput("to17Done", done, 4'b0000);
    idleCycles(2);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("clrHeld", timeoutErr, TO_EN);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("clrDone", timeoutErr, 1'b0);
    idleCycles(1);

    // Transfer lands on the last cycle before timeout: transfer wins.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    for (int c = 1; c <= 15; c++) applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("simDemand", ebusDemand, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("simDone", done, 4'b0010);
    checkOutput("simErr", timeoutErr, 1'b0);
    idleCycles(2);

    // IR drops its request during the settle cycle; DTE is next in rotation.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    checkOutput("abGrant1", grant, 4'b0010);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    checkOutput("abGrant2", grant, 4'b0000);
    checkOutput("abBusy2", busy, 1'b1);
    checkOutput("abDone2", done, 4'b0000);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    checkOutput("abGrant4", grant, 4'b1000);
    idleCycles(5);

    // Asynchronous reset while IR owns the bus in the data phase.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("mrDemand", ebusDemand, 1'b1);
    checkOutput("mrGrant", grant, 4'b0010);
    #2 eboxResetN = 1'b0;
    #1;
    checkOutput("mrGrantLow", grant, 4'b0000);
    checkOutput("mrDemandLow", ebusDemand, 1'b0);
    checkOutput("mrBusyLow", busy, 1'b0);
    req = 4'b1111;
    @(negedge eboxClk);
    eboxResetN = 1'b1;
    @(posedge eboxClk);
    @(negedge eboxClk);
    checkOutput("mrFirstGrant", grant, 4'b0001);
    idleCycles(3);

    // Randomized traffic: alternating fast and slow target phases.
    rnd     = 4'b0000;
    xferPct = 40;
    for (int n = 0; n < 2000; n++) begin
      if (n % 250 == 0) xferPct = ((n / 250) % 2 == 1) ? 3 : 40;
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 15) == 0) rnd[b] = ~rnd[b];
      end
      applyStimulus(rnd, ($urandom_range(0, 99) < xferPct), ($urandom_range(0, 15) == 0));
    end
    idleCycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
